// File: rtl/dual_issue_buffer.sv
// Dual-issue instruction buffer: a circular queue of 32-bit instructions filled a pair at a
// time by fetch and drained one or two per cycle into an even and an odd pipe. Issue is
// strictly in program order. A pair can dual-issue only when an even instruction is followed
// by an odd one that does not read the older instruction's destination register.
module dual_issue_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              instruction1,
  input  logic [31:0]              instruction2,
  input  logic                     fetch_valid,
  input  logic                     branch_flag,
  input  logic                     stall,
  output logic                     enablePC,
  output logic [31:0]              even_instr,
  output logic                     even_valid,
  output logic [31:0]              odd_instr,
  output logic                     odd_valid,
  output logic                     dual_issued,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Highest occupancy that still leaves room for a full pair.
  localparam logic [CW-1:0] MaxPushCount = CW'(DEPTH - 2);

  logic [31:0]   slot_q [DEPTH];
  logic [PW-1:0] head_q, head_d, head_p1;
  logic [PW-1:0] tail_q, tail_d, tail_p1;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   even_instr_q, even_instr_d;
  logic [31:0]   odd_instr_q, odd_instr_d;
  logic          even_valid_q, even_valid_d;
  logic          odd_valid_q, odd_valid_d;
  logic          dual_q, dual_d;

  logic          push;
  logic [1:0]    pop;
  logic [31:0]   slot_a, slot_b;
  logic          has_one, has_two;
  logic          raw_hazard, can_dual;

  // Room for one more pair; depends only on occupancy, never on stall.
  assign enablePC = (count_q <= MaxPushCount);
  assign push     = fetch_valid & enablePC & ~branch_flag;

  assign head_p1  = head_q + PW'(1);
  assign tail_p1  = tail_q + PW'(1);

  // Candidates are read from pre-push state, so a pair written this edge issues next edge.
  assign slot_a   = slot_q[head_q];
  assign slot_b   = slot_q[head_p1];
  assign has_one  = (count_q != '0);
  assign has_two  = (count_q >= CW'(2));

  // The younger instruction may not read the register the older one writes.
  assign raw_hazard = (slot_b[13:7] == slot_a[6:0]) || (slot_b[20:14] == slot_a[6:0]);
  assign can_dual   = has_two && !slot_a[31] && slot_b[31] && !raw_hazard;

  // Issue selection: decide the next registered issue outputs and how many slots to pop.
  always_comb begin
    even_instr_d = even_instr_q;
    even_valid_d = even_valid_q;
    odd_instr_d  = odd_instr_q;
    odd_valid_d  = odd_valid_q;
    dual_d       = dual_q;
    pop          = 2'd0;
    if (branch_flag) begin
      even_instr_d = '0;
      even_valid_d = 1'b0;
      odd_instr_d  = '0;
      odd_valid_d  = 1'b0;
      dual_d       = 1'b0;
    end else if (!stall) begin
      even_instr_d = '0;
      even_valid_d = 1'b0;
      odd_instr_d  = '0;
      odd_valid_d  = 1'b0;
      dual_d       = 1'b0;
      if (can_dual) begin
        even_instr_d = slot_a;
        even_valid_d = 1'b1;
        odd_instr_d  = slot_b;
        odd_valid_d  = 1'b1;
        dual_d       = 1'b1;
        pop          = 2'd2;
      end else if (has_one) begin
        pop = 2'd1;
        if (slot_a[31]) begin
          odd_instr_d = slot_a;
          odd_valid_d = 1'b1;
        end else begin
          even_instr_d = slot_a;
          even_valid_d = 1'b1;
        end
      end
    end
  end

  // Pointer and occupancy update; a flush returns everything to the empty state.
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = push ? (tail_q + PW'(2)) : tail_q;
    count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop);
    if (branch_flag) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control and issue registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      even_instr_q <= '0;
      even_valid_q <= 1'b0;
      odd_instr_q  <= '0;
      odd_valid_q  <= 1'b0;
      dual_q       <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      even_instr_q <= even_instr_d;
      even_valid_q <= even_valid_d;
      odd_instr_q  <= odd_instr_d;
      odd_valid_q  <= odd_valid_d;
      dual_q       <= dual_d;
    end
  end

  // Slot storage is not reset; stale contents are unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_q[tail_q]  <= instruction1;
      slot_q[tail_p1] <= instruction2;
    end
  end

  assign even_instr  = even_instr_q;
  assign even_valid  = even_valid_q;
  assign odd_instr   = odd_instr_q;
  assign odd_valid   = odd_valid_q;
  assign dual_issued = dual_q;
  assign buf_count   = count_q;

endmodule
